// File: rtl/write_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | write_buffer : posted-write FIFO between D-cache and memory arbiter         |
// |   Optional read-hit forwarding is enabled by defining WRITE_BUFFER_FWD_EN.  |
// |   Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
`ifndef MEMORY_WIDTH
`define MEMORY_WIDTH 128
`endif

module write_buffer #(
  parameter int WIDTH       = `MEMORY_WIDTH,
  parameter int DEPTH       = 4,
  parameter int OFFSET_BITS = $clog2(WIDTH/8)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             c_write_req,
  input  logic [31:0]      c_write_addr,
  input  logic [WIDTH-1:0] c_write_data,
  output logic             c_write_ack,
  input  logic             c_read_req,
  input  logic [31:0]      c_read_addr,
  output logic [WIDTH-1:0] c_read_data,
  output logic             c_read_ack,
  output logic             m_write_req,
  output logic [31:0]      m_write_addr,
  output logic [WIDTH-1:0] m_write_data,
  input  logic             m_write_ack,
  output logic             m_read_req,
  output logic [31:0]      m_read_addr,
  input  logic [WIDTH-1:0] m_read_data,
  input  logic             m_read_ack,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {D_IDLE, D_ISSUE} drain_t;
  typedef enum logic [2:0] {R_IDLE, R_FWD, R_HOLD, R_MEM, R_ACK} read_t;

  logic [31:0]      r_addr [DEPTH];
  logic [WIDTH-1:0] r_data [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  drain_t           r_dstate;
  read_t            r_rstate;

  logic             r_wr_ack;
  logic             r_mw_req;
  logic [31:0]      r_mw_addr;
  logic [WIDTH-1:0] r_mw_data;
  logic             r_cr_ack;
  logic [WIDTH-1:0] r_cr_data;
  logic             r_mr_req;
  logic [31:0]      r_mr_addr;

  logic             w_wr_hit;
  logic [PTR_W-1:0] w_wr_idx;
  logic             w_rd_hit;
  logic [PTR_W-1:0] w_rd_idx;
  logic [PTR_W-1:0] w_idx;
  logic             w_full;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_head_data;

  // Scan oldest to youngest so the last hit found is the youngest match.
  always_comb begin
    w_wr_hit = 1'b0;
    w_wr_idx = '0;
    w_rd_hit = 1'b0;
    w_rd_idx = '0;
    w_idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PTR_W'(i);
      if (CNT_W'(i) < r_count) begin
        if ((r_addr[w_idx][31:OFFSET_BITS] == c_write_addr[31:OFFSET_BITS]) &&
            !((i == 0) && (r_dstate == D_ISSUE))) begin
          w_wr_hit = 1'b1;
          w_wr_idx = w_idx;
        end
        if (r_addr[w_idx][31:OFFSET_BITS] == c_read_addr[31:OFFSET_BITS]) begin
          w_rd_hit = 1'b1;
          w_rd_idx = w_idx;
        end
      end
    end
  end

  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_accept = c_write_req & ~r_wr_ack & (w_wr_hit | ~w_full);
  assign w_push   = w_accept & ~w_wr_hit;
  assign w_pop    = (r_dstate == D_ISSUE) & m_write_ack;

  // A coalesce into the head on the same edge the drain launches must not be lost.
  assign w_head_data = (w_accept && w_wr_hit && (w_wr_idx == r_head)) ? c_write_data
                                                                      : r_data[r_head];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= c_write_addr;
      r_data[r_tail] <= c_write_data;
    end else if (w_accept) begin
      r_data[w_wr_idx] <= c_write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_wr_ack <= 1'b0;
    end else begin
      r_wr_ack <= w_accept;
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dstate  <= D_IDLE;
      r_mw_req  <= 1'b0;
      r_mw_addr <= '0;
      r_mw_data <= '0;
    end else begin
      case (r_dstate)
        D_IDLE: begin
          if (r_count != '0) begin
            r_dstate  <= D_ISSUE;
            r_mw_req  <= 1'b1;
            r_mw_addr <= r_addr[r_head];
            r_mw_data <= w_head_data;
          end
        end
        D_ISSUE: begin
          if (m_write_ack) begin
            r_dstate <= D_IDLE;
            r_mw_req <= 1'b0;
          end
        end
        default: r_dstate <= D_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rstate  <= R_IDLE;
      r_cr_ack  <= 1'b0;
      r_cr_data <= '0;
      r_mr_req  <= 1'b0;
      r_mr_addr <= '0;
    end else begin
      r_cr_ack <= 1'b0;
      case (r_rstate)
        R_IDLE: begin
          // The request is still high during the ack pulse; do not restart on it.
          if (c_read_req && !r_cr_ack) begin
            if (w_rd_hit) begin
`ifdef WRITE_BUFFER_FWD_EN
              r_rstate <= R_FWD;
`else
              r_rstate <= R_HOLD;
`endif
            end else begin
              r_rstate  <= R_MEM;
              r_mr_req  <= 1'b1;
              r_mr_addr <= c_read_addr;
            end
          end
        end
`ifdef WRITE_BUFFER_FWD_EN
        R_FWD: begin
          if (w_rd_hit) begin
            r_cr_data <= r_data[w_rd_idx];
            r_cr_ack  <= 1'b1;
            r_rstate  <= R_IDLE;
          end else begin
            r_rstate  <= R_MEM;
            r_mr_req  <= 1'b1;
            r_mr_addr <= c_read_addr;
          end
        end
`endif
        R_HOLD: begin
          if (!w_rd_hit) begin
            r_rstate  <= R_MEM;
            r_mr_req  <= 1'b1;
            r_mr_addr <= c_read_addr;
          end
        end
        R_MEM: begin
          if (m_read_ack) begin
            r_cr_data <= m_read_data;
            r_cr_ack  <= 1'b1;
            r_mr_req  <= 1'b0;
            r_rstate  <= R_ACK;
          end
        end
        R_ACK:   r_rstate <= R_IDLE;
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign c_write_ack  = r_wr_ack;
  assign c_read_ack   = r_cr_ack;
  assign c_read_data  = r_cr_data;
  assign m_write_req  = r_mw_req;
  assign m_write_addr = r_mw_addr;
  assign m_write_data = r_mw_data;
  assign m_read_req   = r_mr_req;
  assign m_read_addr  = r_mr_addr;
  assign empty        = (r_count == '0);
  assign full         = w_full;

endmodule

`default_nettype wire

// File: tb/tb_write_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_write_buffer : directed and randomized bench for write_buffer            |
// |   Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_write_buffer;

  localparam int W     = 64;
  localparam int DEPTH = 4;
  localparam int OFFB  = 3;

  localparam logic [63:0] D1 = 64'hD1D1_0000_1111_D1D1;
  localparam logic [63:0] D2 = 64'hD2D2_2222_0000_D2D2;
  localparam logic [63:0] D3 = 64'hD3D3_3333_3333_D3D3;
  localparam logic [63:0] D4 = 64'hD4D4_4444_4444_D4D4;
  localparam logic [63:0] D5 = 64'hD5D5_5555_5555_D5D5;
  localparam logic [63:0] DA = 64'hAAAA_0600_0600_AAAA;

  logic          clk = 1'b0;
  logic          reset;
  logic          c_write_req;
  logic [31:0]   c_write_addr;
  logic [W-1:0]  c_write_data;
  logic          c_write_ack;
  logic          c_read_req;
  logic [31:0]   c_read_addr;
  logic [W-1:0]  c_read_data;
  logic          c_read_ack;
  logic          m_write_req;
  logic [31:0]   m_write_addr;
  logic [W-1:0]  m_write_data;
  logic          m_write_ack;
  logic          m_read_req;
  logic [31:0]   m_read_addr;
  logic [W-1:0]  m_read_data;
  logic          m_read_ack;
  logic          empty;
  logic          full;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  write_buffer #(.WIDTH(W), .DEPTH(DEPTH), .OFFSET_BITS(OFFB)) dut (
    .clk(clk), .reset(reset),
    .c_write_req(c_write_req), .c_write_addr(c_write_addr), .c_write_data(c_write_data),
    .c_write_ack(c_write_ack),
    .c_read_req(c_read_req), .c_read_addr(c_read_addr), .c_read_data(c_read_data),
    .c_read_ack(c_read_ack),
    .m_write_req(m_write_req), .m_write_addr(m_write_addr), .m_write_data(m_write_data),
    .m_write_ack(m_write_ack),
    .m_read_req(m_read_req), .m_read_addr(m_read_addr), .m_read_data(m_read_data),
    .m_read_ack(m_read_ack),
    .empty(empty), .full(full)
  );

  // Reference model: the buffer is an ordered list of lines, oldest first.
  typedef struct {
    logic [31:0] a;
    logic [63:0] d;
  } ent_t;

  ent_t        q[$];
  ent_t        e;
  bit          mdl_wack;
  bit          mdl_issue;
  logic [31:0] mdl_ia;
  logic [63:0] mdl_id;
  bit          pend;
  logic [31:0] p_addr;
  logic [63:0] p_data;
  bit          acked;
  bit          seen;
  bit          flag;
  int          hidx;
  int          sz;
  bit          acc;
  bit          pop;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic evict(input logic [31:0] a, input logic [63:0] d, output bit ok);
    ok = 1'b0;
    c_write_req  = 1'b1;
    c_write_addr = a;
    c_write_data = d;
    for (int i = 0; i < 8 && !ok; i++) begin
      tick();
      if (c_write_ack) ok = 1'b1;
    end
    c_write_req = 1'b0;
  endtask

  task automatic wait_mwreq(output bit got);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (m_write_req) got = 1'b1;
      else tick();
    end
  endtask

  task automatic drain_one(input string tag, input logic [31:0] a, input logic [63:0] d);
    bit got;
    wait_mwreq(got);
    chk({tag, "_req"}, 64'(got), 64'd1);
    chk({tag, "_addr"}, 64'(m_write_addr), 64'(a));
    chk({tag, "_data"}, m_write_data, d);
    m_write_ack = 1'b1;
    tick();
    m_write_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    c_write_req = 1'b0; c_write_addr = '0; c_write_data = '0;
    c_read_req = 1'b0;  c_read_addr = '0;
    m_write_ack = 1'b0; m_read_ack = 1'b0; m_read_data = '0;
    tick(); tick();
    chk("rst_c_write_ack", 64'(c_write_ack), 64'd0);
    chk("rst_c_read_ack", 64'(c_read_ack), 64'd0);
    chk("rst_m_write_req", 64'(m_write_req), 64'd0);
    chk("rst_m_read_req", 64'(m_read_req), 64'd0);
    chk("rst_c_read_data", c_read_data, 64'd0);
    chk("rst_m_write_addr", 64'(m_write_addr), 64'd0);
    chk("rst_m_write_data", m_write_data, 64'd0);
    chk("rst_m_read_addr", 64'(m_read_addr), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    reset = 1'b0;
    tick();

    // Single eviction and drain.
    c_write_req = 1'b1; c_write_addr = 32'h100; c_write_data = D1;
    tick();
    chk("t1_ack", 64'(c_write_ack), 64'd1);
    chk("t1_empty_after_push", 64'(empty), 64'd0);
    chk("t1_no_mreq_yet", 64'(m_write_req), 64'd0);
    c_write_req = 1'b0;
    tick();
    chk("t1_ack_pulse", 64'(c_write_ack), 64'd0);
    chk("t1_mreq", 64'(m_write_req), 64'd1);
    chk("t1_maddr", 64'(m_write_addr), 64'h100);
    chk("t1_mdata", m_write_data, D1);
    m_write_ack = 1'b1;
    tick();
    chk("t1_empty_after_ack", 64'(empty), 64'd1);
    chk("t1_mreq_drop", 64'(m_write_req), 64'd0);
    tick(); tick();
    m_write_ack = 1'b0;
    chk("t1_still_empty", 64'(empty), 64'd1);
    chk("t1_no_spurious_req", 64'(m_write_req), 64'd0);

    // Fill to DEPTH with the arbiter stalled; pointers wrap.
    for (int i = 0; i < 4; i++) begin
      evict(32'h500 + 32'(i) * 32'h40, 64'hE000 + 64'(i), acked);
      chk("t2_fill_ack", 64'(acked), 64'd1);
    end
    chk("t2_full", 64'(full), 64'd1);
    c_write_req = 1'b1; c_write_addr = 32'h600; c_write_data = 64'hE004;
    flag = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (c_write_ack) flag = 1'b1;
    end
    chk("t2_fifth_blocked", 64'(flag), 64'd0);
    chk("t2_head_addr", 64'(m_write_addr), 64'h500);
    chk("t2_head_data", m_write_data, 64'hE000);
    m_write_ack = 1'b1;
    tick();
    m_write_ack = 1'b0;
    chk("t2_no_accept_on_pop", 64'(c_write_ack), 64'd0);
    chk("t2_not_full_after_pop", 64'(full), 64'd0);
    tick();
    chk("t2_fifth_ack", 64'(c_write_ack), 64'd1);
    chk("t2_full_again", 64'(full), 64'd1);
    c_write_req = 1'b0;
    for (int i = 1; i < 4; i++)
      drain_one("t2_drain", 32'h500 + 32'(i) * 32'h40, 64'hE000 + 64'(i));
    drain_one("t2_drain5", 32'h600, 64'hE004);
    tick();
    chk("t2_empty", 64'(empty), 64'd1);

    // Coalescing behind an in-flight head.
    evict(32'h600, DA, acked);
    wait_mwreq(seen);
    chk("t3_head_inflight", 64'(seen), 64'd1);
    evict(32'h200, D1, acked);
    evict(32'h204, D2, acked);
    chk("t3_coalesce_ack", 64'(acked), 64'd1);
    drain_one("t3_first", 32'h600, DA);
    drain_one("t3_merged", 32'h200, D2);
    tick(); tick();
    chk("t3_empty", 64'(empty), 64'd1);
    chk("t3_no_third", 64'(m_write_req), 64'd0);

    // Read of a line still held in the buffer.
    evict(32'h300, D3, acked);
    wait_mwreq(seen);
    c_read_req = 1'b1; c_read_addr = 32'h300;
`ifdef WRITE_BUFFER_FWD_EN
    tick();
    chk("t4_fwd_early", 64'(c_read_ack), 64'd0);
    tick();
    chk("t4_fwd_ack", 64'(c_read_ack), 64'd1);
    chk("t4_fwd_data", c_read_data, D3);
    chk("t4_fwd_no_mread", 64'(m_read_req), 64'd0);
    c_read_req = 1'b0;
    drain_one("t4_drain", 32'h300, D3);
    chk("t4_fwd_no_mread_after", 64'(m_read_req), 64'd0);
`else
    flag = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (m_read_req || c_read_ack) flag = 1'b1;
    end
    chk("t4_hold_no_mread", 64'(flag), 64'd0);
    m_write_ack = 1'b1;
    tick();
    m_write_ack = 1'b0;
    chk("t4_hold_after_pop", 64'(m_read_req), 64'd0);
    tick();
    chk("t4_mread_req", 64'(m_read_req), 64'd1);
    chk("t4_mread_addr", 64'(m_read_addr), 64'h300);
    m_read_data = D5; m_read_ack = 1'b1;
    tick();
    m_read_ack = 1'b0;
    chk("t4_read_ack", 64'(c_read_ack), 64'd1);
    chk("t4_read_data", c_read_data, D5);
    c_read_req = 1'b0;
    tick();
`endif

    // Read miss through to memory.
    tick();
    c_read_req = 1'b1; c_read_addr = 32'h400;
    tick();
    chk("t5_mread_req", 64'(m_read_req), 64'd1);
    chk("t5_mread_addr", 64'(m_read_addr), 64'h400);
    tick(); tick();
    chk("t5_no_early_ack", 64'(c_read_ack), 64'd0);
    m_read_data = D4; m_read_ack = 1'b1;
    tick();
    m_read_ack = 1'b0; c_read_req = 1'b0;
    chk("t5_ack", 64'(c_read_ack), 64'd1);
    chk("t5_data", c_read_data, D4);
    chk("t5_mreq_drop", 64'(m_read_req), 64'd0);
    tick();
    chk("t5_ack_pulse", 64'(c_read_ack), 64'd0);

    // Reset while a drain is in flight.
    evict(32'h700, D5, acked);
    wait_mwreq(seen);
    chk("t6_inflight", 64'(seen), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_mreq_drop", 64'(m_write_req), 64'd0);
    chk("t6_empty", 64'(empty), 64'd1);

    // Randomized writes and drains against the list model.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q.delete();
    mdl_wack = 1'b0; mdl_issue = 1'b0; mdl_ia = '0; mdl_id = '0;
    pend = 1'b0; p_addr = '0; p_data = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      chk("rnd_c_write_ack", 64'(c_write_ack), 64'(mdl_wack));
      chk("rnd_empty", 64'(empty), 64'(q.size() == 0));
      chk("rnd_full", 64'(full), 64'(q.size() == DEPTH));
      chk("rnd_m_write_req", 64'(m_write_req), 64'(mdl_issue));
      if (mdl_issue) begin
        chk("rnd_m_write_addr", 64'(m_write_addr), 64'(mdl_ia));
        chk("rnd_m_write_data", m_write_data, mdl_id);
      end
      if (pend && mdl_wack) pend = 1'b0;
      if (!pend && $urandom_range(0, 2) != 0) begin
        pend   = 1'b1;
        p_addr = 32'h1000 + (32'($urandom_range(0, 5)) << OFFB) + 32'($urandom_range(0, 7));
        p_data = {$urandom, $urandom};
      end
      c_write_req  = pend;
      c_write_addr = p_addr;
      c_write_data = p_data;
      m_write_ack  = ($urandom_range(0, 3) == 0);

      sz   = q.size();
      hidx = -1;
      for (int k = sz - 1; k >= 0; k--)
        if (hidx < 0 && !(k == 0 && mdl_issue) && q[k].a[31:OFFB] == c_write_addr[31:OFFB])
          hidx = k;
      acc = c_write_req && !mdl_wack && (hidx >= 0 || sz < DEPTH);
      pop = mdl_issue && m_write_ack;
      if (acc) begin
        if (hidx >= 0) begin
          e = q[hidx];
          e.d = c_write_data;
          q[hidx] = e;
        end else begin
          e.a = c_write_addr;
          e.d = c_write_data;
          q.push_back(e);
        end
      end
      if (pop) begin
        void'(q.pop_front());
        mdl_issue = 1'b0;
      end else if (!mdl_issue && sz > 0) begin
        mdl_issue = 1'b1;
        mdl_ia = q[0].a;
        mdl_id = q[0].d;
      end
      mdl_wack = acc;
      tick();
    end
    c_write_req = 1'b0;
    m_write_ack = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
